// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one-deep sample holding register feeding a 64-slot frame
// serialiser. SCLK = clk/4 and LRCK = clk/256, all derived from one 8-bit counter.
module audio_i2s_tx #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                audio_sclk,
    output logic                audio_lrck,
    output logic                audio_dac,
    output logic                underrun
);

    logic [7:0]          cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
    logic [63:0]         shift_q, shift_d;
    logic                sclk_q, sclk_d;
    logic                lrck_q, lrck_d;
    logic                underrun_q, underrun_d;
    logic                load;
    logic                accept;
    logic [5:0]          slot_d;
    logic [63:0]         frame_w;

    // Bit 63 is slot 0; left MSB sits in slot 1, right MSB in slot 33.
    always_comb begin
        frame_w                 = '0;
        frame_w[62 -: SAMPLE_W] = hold_l_q;
        frame_w[30 -: SAMPLE_W] = hold_r_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        run_d      = run_q;
        shift_d    = shift_q;
        sclk_d     = 1'b0;
        lrck_d     = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;
        slot_d     = 6'd0;

        if (!enable) begin
            cnt_d   = 8'd0;
            run_d   = 1'b0;
            shift_d = '0;
        end else begin
            run_d  = 1'b1;
            // The first enabled edge holds cnt at 0 and loads a fresh frame.
            cnt_d  = run_q ? (cnt_q + 8'd1) : 8'd0;
            load   = !run_q || (cnt_q == 8'd255);
            slot_d = cnt_d[7:2];
            if (load) begin
                shift_d    = hold_full_q ? frame_w : '0;
                underrun_d = !hold_full_q;
            end else if (cnt_d[1:0] == 2'd0) begin
                shift_d = {shift_q[62:0], 1'b0};
            end
            sclk_d = cnt_d[1];
            lrck_d = (slot_d >= 6'd31) && (slot_d <= 6'd62);
        end
    end

    // A load only empties a full hold and an accept only fills an empty one.
    always_comb begin
        accept      = sample_valid && !hold_full_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        if (load && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= 8'd0;
            run_q       <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shift_q     <= '0;
            sclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            shift_q     <= shift_d;
            sclk_q      <= sclk_d;
            lrck_q      <= lrck_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign audio_sclk   = sclk_q;
    assign audio_lrck   = lrck_q;
    assign audio_dac    = shift_q[63];
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a 16-bit and a 24-bit instance share one frame
// decoder that rebuilds each frame from sclk/lrck/dac and checks it in order.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        en16 = 1'b0, en24 = 1'b0;
    logic [15:0] l16 = '0, r16 = '0;
    logic        v16 = 1'b0;
    logic        rdy16, sclk16, lrck16, dac16, und16;
    logic [23:0] l24 = '0, r24 = '0;
    logic        v24 = 1'b0;
    logic        rdy24, sclk24, lrck24, dac24, und24;
    logic        sel = 1'b0;
    logic        m_sclk, m_lrck, m_dac, m_und;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_seen = 0;

    typedef struct {
        logic [63:0] f;
        logic        und;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    audio_i2s_tx #(.SAMPLE_W(16)) u16 (
        .clk(clk), .reset_n(reset_n), .enable(en16),
        .sample_l(l16), .sample_r(r16), .sample_valid(v16), .sample_ready(rdy16),
        .audio_sclk(sclk16), .audio_lrck(lrck16), .audio_dac(dac16), .underrun(und16)
    );

    audio_i2s_tx #(.SAMPLE_W(24)) u24 (
        .clk(clk), .reset_n(reset_n), .enable(en24),
        .sample_l(l24), .sample_r(r24), .sample_valid(v24), .sample_ready(rdy24),
        .audio_sclk(sclk24), .audio_lrck(lrck24), .audio_dac(dac24), .underrun(und24)
    );

    assign m_sclk = sel ? sclk24 : sclk16;
    assign m_lrck = sel ? lrck24 : lrck16;
    assign m_dac  = sel ? dac24  : dac16;
    assign m_und  = sel ? und24  : und16;

    // Expected frame indexed by slot number.
    function automatic logic [63:0] mk_frame(input logic [31:0] l, input logic [31:0] r,
                                             input int w);
        logic [63:0] f;
        f = '0;
        for (int s = 1; s <= w; s++) begin
            f[s]      = l[w-s];
            f[32 + s] = r[w-s];
        end
        return f;
    endfunction

    task automatic push(input logic [63:0] f, input logic und);
        exp_t e;
        e.f   = f;
        e.und = und;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    // Frame decoder / scoreboard monitor
    int          idx = 0;
    int          lowcnt = 100;
    bit          synced = 1'b0;
    bit          und_seen = 1'b0;
    logic        prev_sclk = 1'b0;
    logic [63:0] got = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            idx       = 0;
            lowcnt    = 100;
            synced    = 1'b0;
            und_seen  = 1'b0;
            prev_sclk = 1'b0;
        end else begin
            if (m_und) und_seen = 1'b1;
            if (m_sclk && !prev_sclk) begin
                if (lowcnt >= 3) begin
                    idx    = 0;
                    synced = 1'b1;
                    got    = '0;
                end
                if (synced) begin
                    got[idx] = m_dac;
                    checks++;
                    if (m_lrck !== ((idx >= 31) && (idx <= 62))) begin
                        errors++;
                        $display("FAIL lrck slot %0d got %0b", idx, m_lrck);
                    end
                    if (idx == 63) begin
                        frames_seen++;
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_frame got %h want none", got);
                        end else begin
                            exp_t e;
                            e = q.pop_front();
                            if (got !== e.f) begin
                                errors++;
                                $display("FAIL frame %0d got %h want %h", frames_seen, got, e.f);
                            end
                            checks++;
                            if (und_seen !== e.und) begin
                                errors++;
                                $display("FAIL underrun frame %0d got %0b want %0b",
                                         frames_seen, und_seen, e.und);
                            end
                        end
                        und_seen = 1'b0;
                        got      = '0;
                        idx      = 0;
                    end else begin
                        idx++;
                    end
                end
                lowcnt = 0;
            end else if (!m_sclk) begin
                lowcnt++;
                if (lowcnt == 8) begin
                    synced   = 1'b0;
                    und_seen = 1'b0;
                end
            end
            prev_sclk = m_sclk;
        end
    end

    task automatic send16(input logic [15:0] l, input logic [15:0] r, output int acc_cyc);
        l16     = l;
        r16     = r;
        v16     = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 1000; i++) begin
            if (rdy16) begin
                acc_cyc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        v16 = 1'b0;
        if (acc_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got none want accept");
        end
    endtask

    task automatic wait_und16(input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (und16) begin
                found = 1'b1;
                break;
            end
        end
        chk(nm, found, 1);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 1200; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk(nm, q.size(), 0);
    endtask

    initial begin
        int acc[4];
        int dummy;
        int sclk_r1, sclk_r2, lrck_hi, lrck_lo, dac_ones;
        logic ps, pl;

        #1 reset_n = 1'b0;
        en16 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", rdy16, 1);
        chk("rst_sclk", sclk16, 0);
        chk("rst_lrck", lrck16, 0);
        chk("rst_dac", dac16, 0);
        chk("rst_underrun", und16, 0);

        // Free-running with no sample: first frame underruns
        push(64'd0, 1'b1);
        reset_n = 1'b1;
        wait_und16("first_underrun");
        sclk_r1 = -1; sclk_r2 = -1; lrck_hi = -1; lrck_lo = -1; dac_ones = 0;
        ps = sclk16;
        pl = lrck16;
        for (int k = 1; k <= 252; k++) begin
            @(negedge clk);
            if (sclk16 && !ps) begin
                if (sclk_r1 < 0) sclk_r1 = k;
                else if (sclk_r2 < 0) sclk_r2 = k;
            end
            if (lrck16 && !pl) lrck_hi = k;
            if (!lrck16 && pl) lrck_lo = k;
            if (dac16) dac_ones++;
            ps = sclk16;
            pl = lrck16;
        end
        chk("sclk_first_rise", sclk_r1, 2);
        chk("sclk_period", sclk_r2 - sclk_r1, 4);
        chk("lrck_rise_cnt", lrck_hi, 124);
        chk("lrck_high_len", lrck_lo - lrck_hi, 128);
        chk("dac_idle_ones", dac_ones, 0);

        // Known pair before the next frame
        push(mk_frame(32'h8001, 32'h7FFE, 16), 1'b0);
        send16(16'h8001, 16'h7FFE, dummy);

        // Continuous valid: one accept per frame
        for (int i = 0; i < 4; i++) begin
            push(mk_frame(32'h1000 + i, 32'h2000 + i, 16), 1'b0);
            send16(16'h1000 + 16'(i), 16'h2000 + 16'(i), acc[i]);
            if (i > 0) chk("accept_spacing", acc[i] - acc[i-1], 256);
        end

        // Drop enable at cnt=100 with a pair held
        wait_und16("gap_underrun");
        send16(16'h1357, 16'h9BDF, dummy);
        repeat (99) @(negedge clk);
        en16 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("dis_sclk", sclk16, 0);
            chk("dis_lrck", lrck16, 0);
            chk("dis_dac", dac16, 0);
            chk("dis_underrun", und16, 0);
            chk("dis_hold_kept", rdy16, 0);
        end
        push(mk_frame(32'h1357, 32'h9BDF, 16), 1'b0);
        en16 = 1'b1;
        @(negedge clk);
        chk("reenable_no_underrun", und16, 0);

        // Async reset mid-frame with hold full
        send16(16'hC3C3, 16'h3C3C, dummy);
        repeat (255) @(negedge clk);
        send16(16'h1111, 16'h2222, dummy);
        repeat (61) @(negedge clk);
        chk("pre_rst_sclk", sclk16, 1);
        chk("pre_rst_dac", dac16, 1);
        chk("pre_rst_ready", rdy16, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ready", rdy16, 1);
        chk("arst_sclk", sclk16, 0);
        chk("arst_lrck", lrck16, 0);
        chk("arst_dac", dac16, 0);
        chk("arst_underrun", und16, 0);
        repeat (3) @(negedge clk);
        push(64'd0, 1'b1);
        reset_n = 1'b1;
        wait_drain("drain_after_reset");
        en16 = 1'b0;

        // 24-bit instance
        repeat (20) @(negedge clk);
        sel = 1'b1;
        chk("w24_ready", rdy24, 1);
        l24 = 24'hABCDEF;
        r24 = 24'h123456;
        v24 = 1'b1;
        @(negedge clk);
        v24 = 1'b0;
        chk("w24_accepted", rdy24, 0);
        push(mk_frame(32'hABCDEF, 32'h123456, 24), 1'b0);
        en24 = 1'b1;
        wait_drain("drain_w24");
        en24 = 1'b0;
        repeat (10) @(negedge clk);

        chk("frames_seen", frames_seen, 9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
